// File: rtl/rs_pkg.sv
// Shared types and default code constants for the RS(nn,kk) encoder datapath.
package rs_pkg;
  localparam int RS_NN = 255;
  localparam int RS_KK = 247;
  localparam int RS_TT = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} frame_gen_state_t;
  typedef enum logic [1:0] {PAT_DESC, PAT_ASC, PAT_LFSR, PAT_CONST} rs_pat_t;
endpackage

// File: rtl/rs_pat_lfsr.sv
// Galois LFSR pattern source: one step per adv, reloaded with SEED on load.
import rs_pkg::*;

module rs_pat_lfsr #(
  parameter int DW = 8,
  parameter logic [DW-1:0] POLY = DW'(8'h1D),
  parameter logic [DW-1:0] SEED = DW'(8'hFF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          adv,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= SEED;
    else if (load) q <= SEED;
    else if (adv)  q <= (q << 1) ^ (q[DW-1] ? POLY : '0);
  end
endmodule

// File: rtl/rs_frame_gen.sv
// Framed test-symbol source for the RS encoder: KK-symbol frames, gaps, busy stalls.
module rs_frame_gen
  import rs_pkg::*;
#(
  parameter int KK = RS_KK,
  parameter int DW = 8,
  parameter int GAP = 0,
  parameter int NBLK = 1,
  parameter logic [DW-1:0] POLY = DW'(8'h1D),
  parameter logic [DW-1:0] SEED = DW'(8'hFF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    pat_sel,
  input  logic          busy,
  output logic          din_val,
  output logic          din_sop,
  output logic          din_eop,
  output logic [DW-1:0] din,
  output logic [15:0]   frame_cnt,
  output logic          active,
  output logic          done
);
  localparam int BW = $clog2(KK + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] LAST = BW'(KK - 1);
  localparam logic [15:0] NBLK_W = 16'(NBLK);

  frame_gen_state_t state, state_nxt;
  rs_pat_t          pat_q;
  logic [BW-1:0]    idx;
  logic [GW-1:0]    gap_cnt;
  logic [15:0]      frames_issued;
  logic [DW-1:0]    lfsr_q, sym;
  logic             busy_q, stop_pend;
  logic             start_acc, issue, frame_end;
  logic             val_nxt, sop_nxt, eop_nxt, act_nxt, done_nxt;

  assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
  // busy is looked at one edge late, so a beat needs busy low at the previous edge
  assign issue     = (state == ST_SEND) && !busy_q;
  assign frame_end = issue && (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_SEND;
      ST_SEND: if (frame_end) begin
        if (stop || stop_pend)                                    state_nxt = ST_IDLE;
        else if (NBLK != 0 && (frames_issued + 16'd1) == NBLK_W)  state_nxt = ST_DONE;
        else if (GAP > 0)                                         state_nxt = ST_GAP;
        else                                                      state_nxt = ST_SEND;
      end
      ST_GAP: begin
        if (stop)                               state_nxt = ST_IDLE;
        else if (!busy_q && gap_cnt == '0)      state_nxt = ST_SEND;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (pat_q)
      PAT_DESC: sym = DW'(BW'(KK) - idx);
      PAT_ASC:  sym = DW'(idx);
      PAT_LFSR: sym = lfsr_q;
      default:  sym = SEED;
    endcase
    val_nxt  = issue;
    sop_nxt  = issue && (idx == '0);
    eop_nxt  = frame_end;
    act_nxt  = (state == ST_SEND) || (state == ST_GAP);
    done_nxt = !start_acc && (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= 1'b0;
      stop_pend     <= 1'b0;
      pat_q         <= PAT_DESC;
      idx           <= '0;
      gap_cnt       <= '0;
      frames_issued <= '0;
    end else begin
      busy_q <= busy;
      if (start_acc) begin
        pat_q         <= rs_pat_t'(pat_sel);
        idx           <= '0;
        frames_issued <= '0;
        stop_pend     <= 1'b0;
      end else begin
        if (issue)     idx <= frame_end ? '0 : idx + BW'(1);
        if (frame_end) frames_issued <= frames_issued + 16'd1;
        stop_pend <= (state == ST_SEND) && (state_nxt == ST_SEND) && (stop_pend || stop);
        if (frame_end && state_nxt == ST_GAP)
          gap_cnt <= GW'(GAP - 1);
        else if (state == ST_GAP && !busy_q && gap_cnt != '0)
          gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  // frame_cnt trails frames_issued by one edge so it counts completed frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_val   <= 1'b0;
      din_sop   <= 1'b0;
      din_eop   <= 1'b0;
      din       <= '0;
      frame_cnt <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      din_val   <= val_nxt;
      din_sop   <= sop_nxt;
      din_eop   <= eop_nxt;
      din       <= val_nxt ? sym : '0;
      frame_cnt <= start_acc ? 16'd0 : frames_issued;
      active    <= act_nxt;
      done      <= done_nxt;
    end
  end

  rs_pat_lfsr #(.DW(DW), .POLY(POLY), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_acc),
    .adv   (issue),
    .q     (lfsr_q)
  );
endmodule

// File: tb/tb_rs_frame_gen.sv
// Bench for rs_frame_gen: three parameter sets against a beat-slot reference model.
module tb_rs_frame_gen;
  localparam int KKV [3] = '{247, 5, 1};
  localparam int GAPV [3] = '{3, 0, 1};
  localparam int NBV [3] = '{2, 0, 3};
  localparam logic [7:0] SEEDV [3] = '{8'hFF, 8'h5A, 8'hFF};

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start, stop, busy;
  logic [1:0] pat [3];
  logic [2:0] din_val, din_sop, din_eop, active, done;
  logic [7:0] din [3];
  logic [15:0] frame_cnt [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rs_frame_gen #(.KK(KKV[g]), .DW(8), .GAP(GAPV[g]), .NBLK(NBV[g]),
                   .POLY(8'h1D), .SEED(SEEDV[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .stop(stop[g]), .pat_sel(pat[g]),
      .busy(busy[g]), .din_val(din_val[g]), .din_sop(din_sop[g]), .din_eop(din_eop[g]),
      .din(din[g]), .frame_cnt(frame_cnt[g]), .active(active[g]), .done(done[g]));
  end

  // Reference: a run consumes "slots" (edges where busy was low one edge earlier);
  // each slot in a frame yields a beat, and GAP slots are skipped between frames.
  typedef struct {
    bit run, fin, stopp, bprev;
    int wait_n, idx;
    logic [15:0] frames;
    logic [7:0] lf;
    logic [1:0] pat;
    bit val, sop, eop, act, dn;
    logic [7:0] d;
    logic [15:0] fcnt;
  } mdl_t;
  mdl_t m [3];

  typedef struct {
    bit st, sp, bz, val, sop, eop;
    logic [7:0] d;
    logic [15:0] fc;
    bit act, dn;
  } vec_t;
  vec_t tbl [14];

  int nvec = 0, nbad = 0, cyc = 0;

  function automatic logic [7:0] lstep(logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic mdl_t mstep(mdl_t p, int k, bit st, bit sp, bit bz, logic [1:0] ps);
    mdl_t n = p;
    bit acc = st && !p.run;
    bit slot = !p.bprev;
    n.val = 0; n.sop = 0; n.eop = 0; n.d = 8'h00;
    n.act = p.run;
    n.dn = p.fin && !acc;
    n.fcnt = acc ? 16'd0 : p.frames;
    if (acc) begin
      n.run = 1; n.fin = 0; n.frames = 0; n.idx = 0; n.wait_n = 0; n.stopp = 0;
      n.lf = SEEDV[k]; n.pat = ps;
    end else if (p.run) begin
      if (p.wait_n > 0) begin
        if (sp) n.run = 0;
        else if (slot) n.wait_n = p.wait_n - 1;
      end else begin
        n.stopp = p.stopp || sp;
        if (slot) begin
          n.val = 1;
          n.sop = (p.idx == 0);
          n.eop = (p.idx == KKV[k] - 1);
          case (p.pat)
            2'd0: n.d = 8'(KKV[k] - p.idx);
            2'd1: n.d = 8'(p.idx);
            2'd2: n.d = p.lf;
            default: n.d = SEEDV[k];
          endcase
          n.lf = lstep(p.lf);
          if (n.eop) begin
            n.idx = 0;
            n.frames = p.frames + 16'd1;
            if (n.stopp) begin n.run = 0; n.stopp = 0; end
            else if (NBV[k] != 0 && n.frames == 16'(NBV[k])) begin n.run = 0; n.fin = 1; end
            else n.wait_n = GAPV[k];
          end else n.idx = p.idx + 1;
        end
      end
    end
    n.bprev = bz;
    return n;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s u%0d cyc %0d: got %0h expected %0h", nm, k, cyc, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++)
      m[k] = rst_n ? mstep(m[k], k, start[k], stop[k], busy[k], pat[k]) : '{default: 0};
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      chk("val", k, 32'(din_val[k]), 32'(m[k].val));
      chk("fcnt", k, 32'(frame_cnt[k]), 32'(m[k].fcnt));
      chk("active", k, 32'(active[k]), 32'(m[k].act));
      chk("done", k, 32'(done[k]), 32'(m[k].dn));
      if (m[k].val) begin
        chk("sop", k, 32'(din_sop[k]), 32'(m[k].sop));
        chk("eop", k, 32'(din_eop[k]), 32'(m[k].eop));
        chk("din", k, 32'(din[k]), 32'(m[k].d));
      end
    end
  endtask

  task automatic idle();
    start = '0; stop = '0; busy = '0;
    for (int k = 0; k < 3; k++) pat[k] = 2'd0;
  endtask

  task automatic go(input int k, input logic [1:0] p);
    pat[k] = p; start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  initial begin
    int s, nb, eop1, sop2, last_eop, stalls, bleft, nsop, neop;
    bit to, bdone, sent;
    logic [7:0] b [3];
    logic [7:0] f2, e;

    // KK=1, GAP=1, NBLK=3, descending: every beat is 0x01 with sop=eop
    tbl[0]  = '{1,0,0, 0,0,0, 8'h00, 16'd0, 0,0};
    tbl[1]  = '{0,0,0, 1,1,1, 8'h01, 16'd0, 1,0};
    tbl[2]  = '{0,0,0, 0,0,0, 8'h00, 16'd1, 1,0};
    tbl[3]  = '{0,0,0, 1,1,1, 8'h01, 16'd1, 1,0};
    tbl[4]  = '{0,0,0, 0,0,0, 8'h00, 16'd2, 1,0};
    tbl[5]  = '{0,0,0, 1,1,1, 8'h01, 16'd2, 1,0};
    tbl[6]  = '{0,0,0, 0,0,0, 8'h00, 16'd3, 0,1};
    tbl[7]  = '{0,0,1, 0,0,0, 8'h00, 16'd3, 0,1};
    tbl[8]  = '{1,0,1, 0,0,0, 8'h00, 16'd0, 0,0};
    tbl[9]  = '{0,0,0, 0,0,0, 8'h00, 16'd0, 1,0};
    tbl[10] = '{0,0,0, 1,1,1, 8'h01, 16'd0, 1,0};
    tbl[11] = '{0,1,0, 0,0,0, 8'h00, 16'd1, 1,0};
    tbl[12] = '{0,0,0, 0,0,0, 8'h00, 16'd1, 0,0};
    tbl[13] = '{0,1,0, 0,0,0, 8'h00, 16'd1, 0,0};

    rst_n = 1'b0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      start[2] = tbl[i].st; stop[2] = tbl[i].sp; busy[2] = tbl[i].bz; pat[2] = 2'd0;
      tick();
      chk("t_val", 2, 32'(din_val[2]), 32'(tbl[i].val));
      if (tbl[i].val) begin
        chk("t_sop", 2, 32'(din_sop[2]), 32'(tbl[i].sop));
        chk("t_eop", 2, 32'(din_eop[2]), 32'(tbl[i].eop));
        chk("t_din", 2, 32'(din[2]), 32'(tbl[i].d));
      end
      chk("t_fcnt", 2, 32'(frame_cnt[2]), 32'(tbl[i].fc));
      chk("t_active", 2, 32'(active[2]), 32'(tbl[i].act));
      chk("t_done", 2, 32'(done[2]), 32'(tbl[i].dn));
    end
    idle();

    // two descending frames with a 3-cycle gap
    go(0, 2'd0); s = cyc;
    nb = 0; eop1 = -1; sop2 = -1; last_eop = -1; to = 1;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (din_val[0]) begin
        if (nb == 0) begin
          chk("a_latency", 0, cyc - s, 1);
          chk("a_sop", 0, 32'(din_sop[0]), 1);
          chk("a_first", 0, 32'(din[0]), 32'h F7);
        end
        if (nb == 246) begin
          eop1 = cyc;
          chk("a_eop", 0, 32'(din_eop[0]), 1);
          chk("a_last", 0, 32'(din[0]), 32'h01);
        end
        if (nb == 247) sop2 = cyc;
        if (din_eop[0]) last_eop = cyc;
        nb++;
      end else if (eop1 > 0 && sop2 < 0)
        chk("a_gap_active", 0, 32'(active[0]), 1);
      if (done[0]) begin to = 0; break; end
    end
    chk("a_timeout", 0, 32'(to), 0);
    chk("a_beats", 0, nb, 494);
    chk("a_gap", 0, sop2 - eop1, 4);
    chk("a_done_lat", 0, cyc - last_eop, 1);
    chk("a_fcnt", 0, 32'(frame_cnt[0]), 2);

    // busy held for 5 cycles once 100 beats have gone out
    go(0, 2'd0);
    nb = 0; stalls = 0; bleft = 0; bdone = 0; to = 1;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (din_val[0]) begin
        nb++;
        if (din_eop[0] && nb == 247) chk("b_eop_din", 0, 32'(din[0]), 32'h01);
      end else if (nb > 0 && nb < 247) stalls++;
      if (bleft > 0) begin
        bleft--;
        if (bleft == 0) busy[0] = 1'b0;
      end else if (nb == 100 && !bdone) begin
        busy[0] = 1'b1; bleft = 5; bdone = 1;
      end
      if (done[0]) begin to = 0; break; end
    end
    chk("b_timeout", 0, 32'(to), 0);
    chk("b_stalls", 0, stalls, 5);
    chk("b_beats", 0, nb, 494);

    // LFSR mode: sequence runs on across the frame boundary
    e = 8'hFF;
    for (int i = 0; i < 247; i++) e = lstep(e);
    go(0, 2'd2);
    nb = 0; f2 = 8'h00; to = 1;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (din_val[0]) begin
        if (nb < 3) b[nb] = din[0];
        if (nb == 247) f2 = din[0];
        nb++;
      end
      if (done[0]) begin to = 0; break; end
    end
    chk("c_timeout", 0, 32'(to), 0);
    chk("c_b0", 0, 32'(b[0]), 32'h FF);
    chk("c_b1", 0, 32'(b[1]), 32'h E3);
    chk("c_b2", 0, 32'(b[2]), 32'h DB);
    chk("c_frame2", 0, 32'(f2), 32'(e));

    // asynchronous reset in the middle of a frame
    go(0, 2'd0);
    nb = 0; to = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (din_val[0]) nb++;
      if (nb == 50) begin to = 0; break; end
    end
    chk("d_timeout", 0, 32'(to), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("d_rst_val", 0, 32'(din_val[0]), 0);
    chk("d_rst_sop", 0, 32'(din_sop[0]), 0);
    chk("d_rst_eop", 0, 32'(din_eop[0]), 0);
    chk("d_rst_din", 0, 32'(din[0]), 0);
    chk("d_rst_fcnt", 0, 32'(frame_cnt[0]), 0);
    chk("d_rst_active", 0, 32'(active[0]), 0);
    chk("d_rst_done", 0, 32'(done[0]), 0);
    tick(); tick();
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (din_val[0]) nb++;
    end
    chk("d_idle_beats", 0, nb, 0);

    // continuous run stopped during frame 2
    go(1, 2'd1);
    nsop = 0; neop = 0; nb = 0; sent = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (stop[1]) stop[1] = 1'b0;
      if (din_val[1]) begin
        nb++;
        if (din_eop[1]) neop++;
        if (din_sop[1]) begin
          nsop++;
          if (nsop == 2 && !sent) begin stop[1] = 1'b1; sent = 1; end
        end
      end
    end
    chk("e_beats", 1, nb, 10);
    chk("e_eops", 1, neop, 2);
    chk("e_fcnt", 1, 32'(frame_cnt[1]), 2);
    chk("e_done", 1, 32'(done[1]), 0);
    chk("e_active", 1, 32'(active[1]), 0);

    // random start/stop/busy/pattern on all three instances
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 3; k++) begin
        start[k] = ($urandom % 40) == 0;
        stop[k]  = ($urandom % ((k == 1) ? 50 : 200)) == 0;
        busy[k]  = ($urandom % 4) == 0;
        pat[k]   = 2'($urandom);
      end
      tick();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
